// File: rtl/alu_pkg.sv
// Shared ALU opcode encodings and widths for the RV32I execute stage and the decoder.
// No configuration macros are used here; the optional ALU_FLAGS_EN feature lives in alu.sv.
package alu_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned SHAMT_W = 5;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLT  = 4'd5;
    localparam logic [3:0] ALU_SLTU = 4'd6;
    localparam logic [3:0] ALU_SLL  = 4'd7;
    localparam logic [3:0] ALU_SRL  = 4'd8;
    localparam logic [3:0] ALU_SRA  = 4'd9;

    // Mirrors a word so one right-shifting datapath can also serve left shifts.
    function automatic logic [XLEN-1:0] bit_reverse(input logic [XLEN-1:0] v);
        logic [XLEN-1:0] r;
        for (int i = 0; i < int'(XLEN); i++) begin
            r[i] = v[XLEN-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/alu_shifter.sv
// Combinational log-stage barrel shifter for SLL/SRL/SRA.
// dir=0 shifts left, dir=1 shifts right; arith selects sign fill on right shifts.
module alu_shifter
    import alu_pkg::*;
(
    input  logic [XLEN-1:0]    a,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic               dir,
    input  logic               arith,
    output logic [XLEN-1:0]    y
);

    logic [XLEN-1:0] stage [SHAMT_W+1];
    logic            fill;

    assign fill     = dir & arith & a[XLEN-1];
    assign stage[0] = dir ? a : bit_reverse(a);

    // Each stage shifts right by 2^k when shamt[k] is set.
    for (genvar k = 0; k < int'(SHAMT_W); k++) begin : g_stage
        localparam int unsigned Sh = 1 << k;
        assign stage[k+1] = shamt[k] ? {{Sh{fill}}, stage[k][XLEN-1:Sh]} : stage[k];
    end

    assign y = dir ? stage[SHAMT_W] : bit_reverse(stage[SHAMT_W]);

endmodule

// File: rtl/alu.sv
// RV32I ALU: zero-latency combinational result/zero plus a valid-qualified registered copy.
// Define ALU_FLAGS_EN to add carry/overflow/negative outputs and the registered flags_q.
module alu
    import alu_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [3:0]      alu_sel,
    input  logic            in_valid,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            out_valid,
    output logic [XLEN-1:0] result_q,
    output logic            zero_q
`ifdef ALU_FLAGS_EN
   ,output logic            carry,
    output logic            overflow,
    output logic            negative,
    output logic [2:0]      flags_q
`endif
);

    logic            sub;
    logic [XLEN-1:0] b_eff;
    logic [XLEN-1:0] sum;
    logic            slt;
    logic            sltu;
    logic [XLEN-1:0] shift_out;

    // SUB is a + ~b + 1 so both ops share one adder.
    assign sub   = (alu_sel == ALU_SUB);
    assign b_eff = sub ? ~b : b;

`ifdef ALU_FLAGS_EN
    logic carry_raw;
    assign {carry_raw, sum} = {1'b0, a} + {1'b0, b_eff} + {{XLEN{1'b0}}, sub};
`else
    assign sum = a + b_eff + {{(XLEN-1){1'b0}}, sub};
`endif

    assign slt  = $signed(a) < $signed(b);
    assign sltu = a < b;

    alu_shifter u_shifter (
        .a     (a),
        .shamt (b[SHAMT_W-1:0]),
        .dir   (alu_sel != ALU_SLL),
        .arith (alu_sel == ALU_SRA),
        .y     (shift_out)
    );

    always_comb begin
        result = '0;
        case (alu_sel)
            ALU_ADD,
            ALU_SUB:  result = sum;
            ALU_AND:  result = a & b;
            ALU_OR:   result = a | b;
            ALU_XOR:  result = a ^ b;
            ALU_SLT:  result = {{(XLEN-1){1'b0}}, slt};
            ALU_SLTU: result = {{(XLEN-1){1'b0}}, sltu};
            ALU_SLL,
            ALU_SRL,
            ALU_SRA:  result = shift_out;
            default:  result = '0;
        endcase
    end

    assign zero = (result == '0);

`ifdef ALU_FLAGS_EN
    logic is_addsub;
    assign is_addsub = (alu_sel == ALU_ADD) || sub;
    // Overflow: operands agree in sign but the sum does not.
    assign carry     = is_addsub & carry_raw;
    assign overflow  = is_addsub & (a[XLEN-1] == b_eff[XLEN-1]) & (sum[XLEN-1] != a[XLEN-1]);
    assign negative  = result[XLEN-1];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            result_q  <= '0;
            zero_q    <= 1'b0;
`ifdef ALU_FLAGS_EN
            flags_q   <= 3'b000;
`endif
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                result_q <= result;
                zero_q   <= zero;
`ifdef ALU_FLAGS_EN
                flags_q  <= {carry, overflow, negative};
`endif
            end
        end
    end

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed vector table, reset/registered-path sequences,
// and randomized stimulus against an arithmetic reference model.
module tb_alu;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] a, b;
    logic [3:0]  alu_sel;
    logic        in_valid;
    logic [31:0] result, result_q;
    logic        zero, out_valid, zero_q;
`ifdef ALU_FLAGS_EN
    logic        carry, overflow, negative;
    logic [2:0]  flags_q;
`endif

    int checks = 0;
    int errors = 0;

    alu dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a),
        .b         (b),
        .alu_sel   (alu_sel),
        .in_valid  (in_valid),
        .result    (result),
        .zero      (zero),
        .out_valid (out_valid),
        .result_q  (result_q),
        .zero_q    (zero_q)
`ifdef ALU_FLAGS_EN
       ,.carry     (carry),
        .overflow  (overflow),
        .negative  (negative),
        .flags_q   (flags_q)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  sel;
        logic [31:0] res;
        logic        z;
    } vec_t;

    vec_t tbl [15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic longint unsigned pow2(input int n);
        return longint'(1) << n;
    endfunction

    // Reference computed with plain integer arithmetic.
    function automatic logic [31:0] model_res(input logic [31:0] x, input logic [31:0] y,
                                              input logic [3:0] sel);
        longint unsigned ux = x;
        longint unsigned uy = y;
        longint          sx = longint'($signed(x));
        longint          sy = longint'($signed(y));
        int              sh = int'(y % 32);
        longint          q;
        case (sel)
            4'd0: return 32'((ux + uy) % pow2(32));
            4'd1: return 32'((ux + pow2(32) - uy) % pow2(32));
            4'd2: return x & y;
            4'd3: return x | y;
            4'd4: return x ^ y;
            4'd5: return (sx < sy) ? 32'd1 : 32'd0;
            4'd6: return (ux < uy) ? 32'd1 : 32'd0;
            4'd7: return 32'((ux * pow2(sh)) % pow2(32));
            4'd8: return 32'(ux / pow2(sh));
            4'd9: begin
                if (sx >= 0) q = sx / longint'(pow2(sh));
                else q = -((-sx + longint'(pow2(sh)) - 1) / longint'(pow2(sh)));
                return 32'(q);
            end
            default: return 32'd0;
        endcase
    endfunction

    // {carry, overflow, negative}
    function automatic logic [2:0] model_flags(input logic [31:0] x, input logic [31:0] y,
                                               input logic [3:0] sel);
        longint unsigned ux = x;
        longint unsigned uy = y;
        longint          sx = longint'($signed(x));
        longint          sy = longint'($signed(y));
        longint          s;
        logic            c = 1'b0, v = 1'b0;
        logic [31:0]     r = model_res(x, y, sel);
        if (sel == 4'd0) begin
            c = (ux + uy) >= pow2(32);
            s = sx + sy;
            v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        end else if (sel == 4'd1) begin
            c = ux >= uy;
            s = sx - sy;
            v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        end
        return {c, v, r[31]};
    endfunction

    logic [31:0] exp_q;
    logic        exp_z;
    logic [2:0]  exp_f;

    initial begin
        tbl[0]  = '{32'd10,        32'd20,   4'd0,  32'd30,        1'b0};
        tbl[1]  = '{32'd20,        32'd10,   4'd1,  32'd10,        1'b0};
        tbl[2]  = '{32'd5,         32'd5,    4'd1,  32'd0,         1'b1};
        tbl[3]  = '{32'hF0F0,      32'h0FF0, 4'd2,  32'h00F0,      1'b0};
        tbl[4]  = '{32'hF0F0,      32'h0FF0, 4'd3,  32'hFFF0,      1'b0};
        tbl[5]  = '{32'hF0F0,      32'h0FF0, 4'd4,  32'hFF00,      1'b0};
        tbl[6]  = '{32'hFFFFFFFB,  32'd3,    4'd5,  32'd1,         1'b0};
        tbl[7]  = '{32'hFFFFFFFB,  32'd3,    4'd6,  32'd0,         1'b1};
        tbl[8]  = '{32'd1,         32'd4,    4'd7,  32'h10,        1'b0};
        tbl[9]  = '{32'hF0,        32'd4,    4'd8,  32'h0F,        1'b0};
        tbl[10] = '{32'hFFFFFFF0,  32'd2,    4'd9,  32'hFFFFFFFC,  1'b0};
        tbl[11] = '{32'd1,         32'h24,   4'd7,  32'h10,        1'b0};
        tbl[12] = '{32'd123,       32'd456,  4'hF,  32'd0,         1'b1};
        tbl[13] = '{32'd3,         32'hFFFFFFFB, 4'd5, 32'd0,      1'b1};
        tbl[14] = '{32'h80000000,  32'h1F,   4'd9,  32'hFFFFFFFF,  1'b0};

        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; alu_sel = '0;
        #12;
        chk("reset out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset result_q", result_q, 32'd0);
        chk("reset zero_q", {31'd0, zero_q}, 32'd0);

        // Directed combinational vectors; also confirms independence from reset.
        for (int i = 0; i < 15; i++) begin
            a = tbl[i].a; b = tbl[i].b; alu_sel = tbl[i].sel;
            #1;
            chk($sformatf("vec%0d result", i), result, tbl[i].res);
            chk($sformatf("vec%0d zero", i), {31'd0, zero}, {31'd0, tbl[i].z});
        end

`ifdef ALU_FLAGS_EN
        a = 32'h7FFFFFFF; b = 32'd1; alu_sel = ALU_ADD; #1;
        chk("flags add ovf", {29'd0, carry, overflow, negative}, 32'b011);
        a = 32'hFFFFFFFF; b = 32'd1; alu_sel = ALU_ADD; #1;
        chk("flags add carry", {29'd0, carry, overflow, negative}, 32'b100);
        chk("flags add zero", {31'd0, zero}, 32'd1);
        a = 32'd5; b = 32'd5; alu_sel = ALU_SUB; #1;
        chk("flags sub noborrow", {29'd0, carry, overflow, negative}, 32'b100);
        a = 32'd3; b = 32'd5; alu_sel = ALU_SUB; #1;
        chk("flags sub borrow", {29'd0, carry, overflow, negative}, 32'b001);
        a = 32'h80000000; b = 32'h80000000; alu_sel = ALU_XOR; #1;
        chk("flags logic", {29'd0, carry, overflow, negative}, 32'b000);
`endif

        // Capture attempted while reset is held must be dropped.
        a = 32'd10; b = 32'd20; alu_sel = ALU_ADD; in_valid = 1'b1;
        tick();
        chk("held reset out_valid", {31'd0, out_valid}, 32'd0);
        chk("held reset result_q", result_q, 32'd0);
        #2 rst_n = 1'b1;
        tick();
        chk("first cap out_valid", {31'd0, out_valid}, 32'd1);
        chk("first cap result_q", result_q, 32'd30);
        chk("first cap zero_q", {31'd0, zero_q}, 32'd0);
        in_valid = 1'b0; a = 32'd7; b = 32'd7; alu_sel = ALU_SUB;
        tick();
        chk("hold out_valid", {31'd0, out_valid}, 32'd0);
        chk("hold result_q", result_q, 32'd30);
        chk("hold zero_q", {31'd0, zero_q}, 32'd0);
        exp_q = 32'd30; exp_z = 1'b0;
`ifdef ALU_FLAGS_EN
        exp_f = model_flags(32'd10, 32'd20, ALU_ADD);
`else
        exp_f = 3'b000;
`endif

        // Randomized traffic, including back-to-back captures.
        for (int n = 0; n < 400; n++) begin
            logic iv;
            iv = ($urandom_range(0, 3) != 0);
            a  = $urandom;
            case ($urandom_range(0, 3))
                0:       b = a;
                1:       b = $urandom_range(0, 40);
                2:       b = ~a + 32'd1;
                default: b = $urandom;
            endcase
            alu_sel  = 4'($urandom_range(0, 15));
            in_valid = iv;
            #1;
            chk("rnd result", result, model_res(a, b, alu_sel));
            chk("rnd zero", {31'd0, zero}, {31'd0, model_res(a, b, alu_sel) == 32'd0});
            if (iv) begin
                exp_q = model_res(a, b, alu_sel);
                exp_z = (exp_q == 32'd0);
`ifdef ALU_FLAGS_EN
                exp_f = model_flags(a, b, alu_sel);
                chk("rnd flags", {29'd0, carry, overflow, negative}, {29'd0, exp_f});
`endif
            end
            tick();
            chk("rnd out_valid", {31'd0, out_valid}, {31'd0, iv});
            chk("rnd result_q", result_q, exp_q);
            chk("rnd zero_q", {31'd0, zero_q}, {31'd0, exp_z});
`ifdef ALU_FLAGS_EN
            chk("rnd flags_q", {29'd0, flags_q}, {29'd0, exp_f});
`endif
        end

        // Asynchronous reset mid-stream clears outputs before any edge.
        a = 32'hFFFFFFFF; b = 32'd1; alu_sel = ALU_ADD; in_valid = 1'b1;
        tick();
        a = 32'd40; b = 32'd2; alu_sel = ALU_OR;
        tick();
        chk("pre-reset result_q", result_q, 32'd42);
        #3 rst_n = 1'b0;
        #1;
        chk("async out_valid", {31'd0, out_valid}, 32'd0);
        chk("async result_q", result_q, 32'd0);
        chk("async zero_q", {31'd0, zero_q}, 32'd0);
`ifdef ALU_FLAGS_EN
        chk("async flags_q", {29'd0, flags_q}, 32'd0);
`endif
        chk("comb during reset", result, 32'd42);
        tick();
        chk("reset held result_q", result_q, 32'd0);
        #3 rst_n = 1'b1;
        a = 32'd9; b = 32'd9; alu_sel = ALU_SUB; in_valid = 1'b1;
        tick();
        chk("post-reset out_valid", {31'd0, out_valid}, 32'd1);
        chk("post-reset result_q", result_q, 32'd0);
        chk("post-reset zero_q", {31'd0, zero_q}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
